// File: rtl/mmss_stopwatch.sv
// mmss_stopwatch: minutes:seconds stopwatch (00:00 .. 59:59) with BCD digit
// outputs, start/stop/clear control FSM and a tick prescaler.
// Optional lap-hold display freeze is compiled in with LAP_HOLD_EN.
module mmss_stopwatch #(
  parameter int TICKS_PER_SEC = 10,
  parameter int PRE_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] sec_u,
  output logic [2:0] sec_t,
  output logic [3:0] min_u,
  output logic [2:0] min_t,
  output logic       running,
  output logic       overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);

  state_t           state_reg, state_next;
  logic [PRE_W-1:0] pre_reg, pre_next;
  logic [3:0]       sec_u_reg, sec_u_next;
  logic [2:0]       sec_t_reg, sec_t_next;
  logic [3:0]       min_u_reg, min_u_next;
  logic [2:0]       min_t_reg, min_t_next;
  logic             overflow_reg, overflow_next;
  logic             count_tick;

  // Control FSM next state; clear beats stop, stop beats start.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (!clear && !stop && start) state_next = RUN;
      end
      RUN: begin
        if (clear)     state_next = IDLE;
        else if (stop) state_next = PAUSE;
      end
      PAUSE: begin
        if (clear)               state_next = IDLE;
        else if (!stop && start) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  // A tick only counts in RUN when no state change is requested this cycle.
  assign count_tick = (state_reg == RUN) && tick && !clear && !stop;

  // Prescaler and cascaded digit counters; leaving for IDLE zeroes everything.
  always_comb begin
    pre_next      = pre_reg;
    sec_u_next    = sec_u_reg;
    sec_t_next    = sec_t_reg;
    min_u_next    = min_u_reg;
    min_t_next    = min_t_reg;
    overflow_next = 1'b0;
    if (state_next == IDLE) begin
      pre_next   = '0;
      sec_u_next = 4'd0;
      sec_t_next = 3'd0;
      min_u_next = 4'd0;
      min_t_next = 3'd0;
    end else if (count_tick) begin
      if (pre_reg >= PRE_LAST) begin
        pre_next = '0;
        if (sec_u_reg >= 4'd9) begin
          sec_u_next = 4'd0;
          if (sec_t_reg >= 3'd5) begin
            sec_t_next = 3'd0;
            if (min_u_reg >= 4'd9) begin
              min_u_next = 4'd0;
              if (min_t_reg >= 3'd5) begin
                min_t_next    = 3'd0;
                overflow_next = 1'b1;
              end else begin
                min_t_next = min_t_reg + 3'd1;
              end
            end else begin
              min_u_next = min_u_reg + 4'd1;
            end
          end else begin
            sec_t_next = sec_t_reg + 3'd1;
          end
        end else begin
          sec_u_next = sec_u_reg + 4'd1;
        end
      end else begin
        pre_next = pre_reg + 1'b1;
      end
    end
  end

  // State, prescaler, digit and overflow registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      pre_reg      <= '0;
      sec_u_reg    <= 4'd0;
      sec_t_reg    <= 3'd0;
      min_u_reg    <= 4'd0;
      min_t_reg    <= 3'd0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pre_reg      <= pre_next;
      sec_u_reg    <= sec_u_next;
      sec_t_reg    <= sec_t_next;
      min_u_reg    <= min_u_next;
      min_t_reg    <= min_t_next;
      overflow_reg <= overflow_next;
    end
  end

  assign running  = (state_reg == RUN);
  assign overflow = overflow_reg;

`ifdef LAP_HOLD_EN
  logic       hold_reg, hold_next;
  logic [3:0] hold_sec_u_reg, hold_min_u_reg;
  logic [2:0] hold_sec_t_reg, hold_min_t_reg;
  logic       lap_take;

  // A lap pulse in RUN toggles the hold; clear always releases it.
  assign lap_take = (state_reg == RUN) && lap && !clear;

  always_comb begin
    hold_next = hold_reg;
    if (clear)         hold_next = 1'b0;
    else if (lap_take) hold_next = !hold_reg;
  end

  // Hold flag and snapshot of the live digits taken when the hold engages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_reg       <= 1'b0;
      hold_sec_u_reg <= 4'd0;
      hold_sec_t_reg <= 3'd0;
      hold_min_u_reg <= 4'd0;
      hold_min_t_reg <= 3'd0;
    end else begin
      hold_reg <= hold_next;
      if (lap_take && !hold_reg) begin
        hold_sec_u_reg <= sec_u_reg;
        hold_sec_t_reg <= sec_t_reg;
        hold_min_u_reg <= min_u_reg;
        hold_min_t_reg <= min_t_reg;
      end
    end
  end

  assign sec_u = hold_reg ? hold_sec_u_reg : sec_u_reg;
  assign sec_t = hold_reg ? hold_sec_t_reg : sec_t_reg;
  assign min_u = hold_reg ? hold_min_u_reg : min_u_reg;
  assign min_t = hold_reg ? hold_min_t_reg : min_t_reg;
`else
  logic unused_lap;
  assign unused_lap = lap;

  assign sec_u = sec_u_reg;
  assign sec_t = sec_t_reg;
  assign min_u = min_u_reg;
  assign min_t = min_t_reg;
`endif

endmodule

// File: tb/tb_mmss_stopwatch.sv
// Testbench for mmss_stopwatch: two instances share stimulus, one with
// TICKS_PER_SEC = 10 (dut0) and one with TICKS_PER_SEC = 1 (dut1).
module tb_mmss_stopwatch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0, lap = 1'b0;

  logic [3:0] sec_u0, min_u0, sec_u1, min_u1;
  logic [2:0] sec_t0, min_t0, sec_t1, min_t1;
  logic       running0, overflow0, running1, overflow1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mmss_stopwatch #(.TICKS_PER_SEC(10), .PRE_W(8)) dut0 (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop),
    .clear(clear), .lap(lap),
    .sec_u(sec_u0), .sec_t(sec_t0), .min_u(min_u0), .min_t(min_t0),
    .running(running0), .overflow(overflow0)
  );

  mmss_stopwatch #(.TICKS_PER_SEC(1), .PRE_W(8)) dut1 (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop),
    .clear(clear), .lap(lap),
    .sec_u(sec_u1), .sec_t(sec_t1), .min_u(min_u1), .min_t(min_t1),
    .running(running1), .overflow(overflow1)
  );

  typedef struct {
    string      name;
    logic       start, stop, clear, tick;
    logic [2:0] mt;
    logic [3:0] mu;
    logic [2:0] st;
    logic [3:0] su;
    logic       run, ovf;
  } vec_t;

  vec_t vecs [11];

  // Compare one DUT's display, running and overflow against expectations.
  task automatic chk(input string nm, input int which,
                     input logic [2:0] mt, input logic [3:0] mu,
                     input logic [2:0] st, input logic [3:0] su,
                     input logic run, input logic ovf);
    logic [15:0] act, exp;
    exp = {mt, mu, st, su, run, ovf};
    if (which == 0) act = {min_t0, min_u0, sec_t0, sec_u0, running0, overflow0};
    else            act = {min_t1, min_u1, sec_t1, sec_u1, running1, overflow1};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d: got %0d%0d:%0d%0d run=%0b ovf=%0b, expected %0d%0d:%0d%0d run=%0b ovf=%0b",
               nm, which, act[15:13], act[12:9], act[8:6], act[5:2], act[1], act[0],
               mt, mu, st, su, run, ovf);
    end else begin
      $display("  ok %s dut%0d: %0d%0d:%0d%0d run=%0b ovf=%0b",
               nm, which, mt, mu, st, su, run, ovf);
    end
  endtask

  // Apply one cycle of inputs; sample 1 time unit after the edge.
  task automatic step(input logic s, input logic p, input logic c,
                      input logic t, input logic l);
    start = s; stop = p; clear = c; tick = t; lap = l;
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0; clear = 1'b0; tick = 1'b0; lap = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    // Per-cycle vectors checked against dut1 (one tick = one second).
    vecs[0]  = '{"idle_tick_ignored", 0,0,0,1, 3'd0,4'd0,3'd0,4'd0, 0,0};
    vecs[1]  = '{"start_run",         1,0,0,0, 3'd0,4'd0,3'd0,4'd0, 1,0};
    vecs[2]  = '{"tick1",             0,0,0,1, 3'd0,4'd0,3'd0,4'd1, 1,0};
    vecs[3]  = '{"tick2",             0,0,0,1, 3'd0,4'd0,3'd0,4'd2, 1,0};
    vecs[4]  = '{"stop_beats_tick",   0,1,0,1, 3'd0,4'd0,3'd0,4'd2, 0,0};
    vecs[5]  = '{"pause_tick_ign",    0,0,0,1, 3'd0,4'd0,3'd0,4'd2, 0,0};
    vecs[6]  = '{"resume",            1,0,0,0, 3'd0,4'd0,3'd0,4'd2, 1,0};
    vecs[7]  = '{"start_tick_run",    1,0,0,1, 3'd0,4'd0,3'd0,4'd3, 1,0};
    vecs[8]  = '{"clear_all_inputs",  1,1,1,1, 3'd0,4'd0,3'd0,4'd0, 0,0};
    vecs[9]  = '{"restart",           1,0,0,0, 3'd0,4'd0,3'd0,4'd0, 1,0};
    vecs[10] = '{"tick_after_restart",0,0,0,1, 3'd0,4'd0,3'd0,4'd1, 1,0};

    // Reset state while rst is held.
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 0, 0,0,0,0, 0,0);
    chk("reset", 1, 0,0,0,0, 0,0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      step(vecs[i].start, vecs[i].stop, vecs[i].clear, vecs[i].tick, 1'b0);
      chk(vecs[i].name, 1, vecs[i].mt, vecs[i].mu, vecs[i].st, vecs[i].su,
          vecs[i].run, vecs[i].ovf);
    end

    // Ten ticks make one second at TICKS_PER_SEC = 10.
    step(0,0,1,0,0);
    step(1,0,0,0,0);
    ticks(9);
    chk("nine_ticks", 0, 0,0,0,0, 1,0);
    ticks(1);
    chk("ten_ticks", 0, 0,0,0,1, 1,0);
    chk("ten_ticks", 1, 0,0,1,0, 1,0);

    // 600 ticks with TICKS_PER_SEC = 1, checking the 00:59 -> 01:00 carry.
    step(0,0,1,0,0);
    step(1,0,0,0,0);
    ticks(59);
    chk("at_00_59", 1, 0,0,5,9, 1,0);
    ticks(1);
    chk("at_01_00", 1, 0,1,0,0, 1,0);
    ticks(540);
    chk("at_10_00", 1, 1,0,0,0, 1,0);
    chk("sixty_sec", 0, 0,1,0,0, 1,0);

    // Wrap 59:59 -> 00:00 with a single-cycle overflow pulse.
    step(0,0,1,0,0);
    step(1,0,0,0,0);
    ticks(3598);
    chk("at_59_58", 1, 5,9,5,8, 1,0);
    ticks(1);
    chk("at_59_59", 1, 5,9,5,9, 1,0);
    ticks(1);
    chk("wrap", 1, 0,0,0,0, 1,1);
    step(0,0,0,0,0);
    chk("ovf_one_cycle", 1, 0,0,0,0, 1,0);
    ticks(1);
    chk("count_after_wrap", 1, 0,0,0,1, 1,0);

    // Pause/resume keeps the prescaler phase (TICKS_PER_SEC = 10).
    step(0,0,1,0,0);
    step(1,0,0,0,0);
    ticks(5);
    step(0,1,0,0,0);
    ticks(20);
    chk("paused", 0, 0,0,0,0, 0,0);
    step(1,0,0,0,0);
    ticks(4);
    chk("resume_4", 0, 0,0,0,0, 1,0);
    ticks(1);
    chk("resume_5", 0, 0,0,0,1, 1,0);

    // Simultaneous controls at 00:07, then asynchronous reset mid-count.
    step(0,0,1,0,0);
    step(1,0,0,0,0);
    ticks(7);
    chk("at_00_07", 1, 0,0,0,7, 1,0);
    step(1,1,1,1,0);
    chk("all_ctrl", 1, 0,0,0,0, 0,0);
    step(1,0,0,0,0);
    ticks(12);
    chk("pre_rst", 1, 0,0,1,2, 1,0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst", 1, 0,0,0,0, 0,0);
    chk("async_rst", 0, 0,0,0,0, 0,0);
    @(negedge clk);
    rst = 1'b0;
    ticks(3);
    chk("after_rst_idle", 1, 0,0,0,0, 0,0);

    // Lap behaviour.
    step(1,0,0,0,0);
    ticks(3);
    step(0,0,0,0,1);
    chk("lap_first", 1, 0,0,0,3, 1,0);
    ticks(20);
`ifdef LAP_HOLD_EN
    chk("lap_held", 1, 0,0,0,3, 1,0);
    step(0,0,0,0,1);
    chk("lap_release", 1, 0,0,2,3, 1,0);
`else
    chk("lap_ignored", 1, 0,0,2,3, 1,0);
    step(0,0,0,0,1);
    chk("lap_again", 1, 0,0,2,3, 1,0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmss_stopwatch.md
Name: mmss_stopwatch

Overview:
- Minutes:seconds stopwatch stage (00:00 to 59:59).
- Consumes a one-cycle tick pulse from the upstream prescaler/free-running counter.
- Produces BCD digits for the display stage. Both tens digits are mod-6 counters and units digits are mod-10, cascaded by carry.
- Start/stop/clear control FSM governs counting.

Parameters:
- TICKS_PER_SEC, 10, number of tick pulses per elapsed second; legal range 1..255.
- PRE_W, 8, width of the internal tick prescaler; must satisfy 2^PRE_W >= TICKS_PER_SEC.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- tick  input  1  one-cycle count-enable pulse from the upstream prescaler.
- start  input  1  level-sampled each cycle; begins or resumes counting.
- stop  input  1  level-sampled; pauses counting.
- clear  input  1  level-sampled; returns to 00:00 and IDLE.
- lap  input  1  lap-hold request; used only with LAP_HOLD_EN.
- sec_u  output  4  seconds units digit, 0..9.
- sec_t  output  3  seconds tens digit, 0..5.
- min_u  output  4  minutes units digit, 0..9.
- min_t  output  3  minutes tens digit, 0..5.
- running  output  1  high while in RUN.
- overflow  output  1  one-cycle pulse on 59:59 to 00:00 wrap.

Behaviour:
- Clock and reset: one clock (clk). rst is asynchronous and active-high.
- Reset values: FSM = IDLE, prescaler = 0, all digits = 0, running = 0, overflow = 0, lap hold cleared.
- FSM states: IDLE, RUN, PAUSE.
- Control priority when inputs are simultaneous: clear > stop > start.
- IDLE transitions:
  - start -> RUN.
  - clear -> stay IDLE.
  - Digits and prescaler are held at 0.
- RUN transitions:
  - clear -> IDLE, zeroing digits and prescaler in the same edge.
  - stop -> PAUSE.
  - Otherwise stay RUN.
- PAUSE transitions:
  - clear -> IDLE with zeroing.
  - start -> RUN.
  - Otherwise hold all state. Prescaler is retained, so a resumed second is not shortened or lengthened.
- Prescaler and second advance:
  - Only in RUN and only when tick = 1, prescaler increments.
  - When prescaler = TICKS_PER_SEC-1 and tick = 1: prescaler -> 0 and the time advances by one second.
  - With TICKS_PER_SEC = 1, every tick is one second.
- Ticks outside RUN are ignored.
- A tick in the same cycle as stop or clear is ignored; the state change wins.
- Digit cascade on a second advance:
  - sec_u: 9 -> 0 with carry.
  - sec_t: 5 -> 0 with carry.
  - min_u: 9 -> 0 with carry.
  - min_t: 5 -> 0 with carry.
  - 59:59 -> 00:00 wraps; overflow pulses high for exactly one cycle; counting continues.
- Latency: digits, running and overflow are registered and change on the clock edge that samples the qualifying tick. running reflects the new state on that same edge.
- Digits never take values outside their range. There are no illegal states; an unencoded FSM code recovers to IDLE.
- rst asserted mid-count: immediate return to the reset values, independent of clk.

Optional Feature:
- Macro: LAP_HOLD_EN.
- With LAP_HOLD_EN defined:
  - lap = 1 in RUN snapshots the live digits into hold registers.
  - Outputs show the frozen snapshot while internal counting continues.
  - A second lap pulse, or clear, releases the hold. On release, outputs show live digits from the next edge.
  - In IDLE or PAUSE, lap is ignored.
  - A transition to PAUSE keeps an active hold.
- Without LAP_HOLD_EN: the lap port exists but is ignored; outputs always show live digits; no hold registers are synthesized.

Test Plan:
- Reset, then start, then 10 ticks (TICKS_PER_SEC = 10): running = 1; after the 10th tick the display reads 00:01 (sec_u = 1); after 9 ticks it still reads 00:00.
- Run 600 ticks from 00:00 with TICKS_PER_SEC = 1: reads 10:00, showing the sec_t 5 -> 0 carry into min_u at 00:59 -> 01:00.
- Preload 59:58 by running, then 2 ticks: reads 59:59 then 00:00; overflow is high for exactly 1 cycle on the wrap.
- Pause/resume: start, 5 ticks, stop, 20 ticks, start, 5 ticks (TPS = 10): reads 00:01. running is 0 during the pause; paused ticks are ignored.
- Simultaneous controls: clear + stop + start + tick in RUN at 00:07 -> state IDLE, reads 00:00. rst pulsed mid-count (asynchronous, between edges) zeroes all outputs immediately.
- With LAP_HOLD_EN: lap at 00:03, 20 more seconds -> outputs hold 00:03; second lap -> next edge shows 00:23. Without the macro, lap has no effect on any output.
